// File: rtl/instruction_fetch.sv
// Instruction fetch stage.
// Requests instruction words from memory and keeps at most two requests or
// buffered words in flight, using a credit scheme. Words are handed to decode
// in request order. A redirect moves the fetch PC to a new target, empties the
// buffer and drops the responses that are still in flight.

module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc
);

    logic [31:0] fetch_pc;
    logic [1:0]  outstanding;
    logic [1:0]  discard;
    logic [1:0]  count;
    logic        head;
    logic [31:0] buf_pc   [2];
    logic [31:0] buf_word [2];

    logic        accept;
    logic        pop;
    logic        rsp_keep;
    logic        tail;
    logic [2:0]  credit_used;
    logic [31:0] rsp_pc;
    logic [1:0]  in_flight_left;

    // Handshakes and bookkeeping derived from the current state. A live
    // response always belongs to the oldest live request, whose PC is the
    // fetch PC wound back by one word per live request still in flight.
    always_comb begin
        credit_used    = {1'b0, outstanding} + {1'b0, count};
        accept         = imem_req_valid && imem_req_ready;
        pop            = instr_valid && instr_ready;
        rsp_keep       = imem_rsp_valid && !redirect_valid &&
                         (discard == 2'd0) && (outstanding != 2'd0);
        tail           = head ^ count[0];
        rsp_pc         = fetch_pc - {28'd0, outstanding, 2'b00};
        in_flight_left = outstanding + discard;
        if (imem_rsp_valid && (in_flight_left != 2'd0)) begin
            in_flight_left = in_flight_left - 2'd1;
        end
    end

    // Outputs come from registered state only; rst and redirect merely
    // gate them, so memory responses and decode backpressure never reach
    // instr_valid or imem_req_valid in the same cycle.
    assign imem_req_valid = !rst && !redirect_valid && (discard == 2'd0) &&
                            (credit_used < 3'd2);
    assign imem_addr      = fetch_pc;
    assign instr_valid    = !rst && (count != 2'd0);
    assign instruction    = instr_valid ? buf_word[head] : 32'd0;
    assign instr_pc       = instr_valid ? buf_pc[head]   : 32'd0;

    // Control state: fetch PC, in-flight counters and buffer pointers.
    // A redirect overrides any same-cycle pop or response write.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            outstanding <= 2'd0;
            discard     <= 2'd0;
            count       <= 2'd0;
            head        <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc    <= {redirect_pc[31:2], 2'b00};
            outstanding <= 2'd0;
            discard     <= in_flight_left;
            count       <= 2'd0;
            head        <= 1'b0;
        end else begin
            if (accept) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (accept && !rsp_keep) begin
                outstanding <= outstanding + 2'd1;
            end else if (!accept && rsp_keep) begin
                outstanding <= outstanding - 2'd1;
            end
            if (imem_rsp_valid && (discard != 2'd0)) begin
                discard <= discard - 2'd1;
            end
            if (pop) begin
                head <= ~head;
            end
            if (rsp_keep && !pop) begin
                count <= count + 2'd1;
            end else if (!rsp_keep && pop) begin
                count <= count - 2'd1;
            end
        end
    end

    // Buffer storage needs no reset; the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (rsp_keep) begin
            buf_pc[tail]   <= rsp_pc;
            buf_word[tail] <= imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch.
// A transaction-level model tracks the requests in flight and the words that
// decode should see. It is driven by directed phases and then by random traffic.

module tb_instruction_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'd0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instruction;
    logic [31:0] instr_pc;

    instruction_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instruction    (instruction),
        .instr_pc       (instr_pc)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        bit          live;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } ent_t;

    req_t        inflight[$];
    ent_t        decode_q[$];
    logic [31:0] model_pc = RESET_PC;
    bit          model_valid = 1'b0;
    logic [31:0] accept_log[$];
    logic [31:0] pop_log[$];
    int          rsp_prob = 100;
    int          assert_count = 0;
    int          fail_count = 0;
    logic [31:0] stall_addr;

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ({a[15:0], a[31:16]} ^ 32'h5A5A_C3C3) + a;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkLog(input string tag, input logic [31:0] q[$],
                            input int idx, input logic [31:0] expected);
        logic [31:0] val;
        val = 'x;
        if (idx < q.size()) val = q[idx];
        checkOutput(tag, val, expected);
    endtask

    // One clock cycle: drive inputs at the falling edge, check outputs
    // against the model, then advance the model at the rising edge.
    task automatic applyStimulus(input bit rst_in, input bit rdy_in,
                                 input bit irdy_in, input bit redir_in,
                                 input logic [31:0] rpc_in);
        bit   exp_req;
        bit   exp_ivalid;
        bit   do_rsp;
        bit   do_accept;
        bit   do_pop;
        bit   stale;
        req_t r;

        @(negedge clk);
        rst            = rst_in;
        imem_req_ready = rdy_in;
        instr_ready    = irdy_in;
        redirect_valid = redir_in;
        redirect_pc    = rpc_in;
        do_rsp         = !rst_in && (inflight.size() != 0) &&
                         ($urandom_range(99) < rsp_prob);
        imem_rsp_valid = do_rsp;
        imem_rsp_data  = do_rsp ? mem_word(inflight[0].pc) : $urandom;
        #1;

        exp_req    = 1'b0;
        exp_ivalid = 1'b0;
        if (model_valid) begin
            if (rst_in) begin
                checkOutput("rst_req_valid", imem_req_valid, 0);
                checkOutput("rst_instr_valid", instr_valid, 0);
                checkOutput("rst_instruction", instruction, 0);
                checkOutput("rst_instr_pc", instr_pc, 0);
            end else begin
                stale = 1'b0;
                foreach (inflight[i]) if (!inflight[i].live) stale = 1'b1;
                exp_req = !redir_in && !stale &&
                          ((inflight.size() + decode_q.size()) < 2);
                checkOutput("req_valid", imem_req_valid, exp_req);
                if (exp_req) checkOutput("imem_addr", imem_addr, model_pc);
                exp_ivalid = decode_q.size() != 0;
                checkOutput("instr_valid", instr_valid, exp_ivalid);
                if (exp_ivalid) begin
                    checkOutput("instr_pc", instr_pc, decode_q[0].pc);
                    checkOutput("instruction", instruction, decode_q[0].word);
                end
            end
        end

        if (!rst_in && (imem_req_valid === 1'b1) && rdy_in)
            accept_log.push_back(imem_addr);
        if (!rst_in && !redir_in && (instr_valid === 1'b1) && irdy_in)
            pop_log.push_back(instr_pc);

        do_accept = exp_req && rdy_in;
        do_pop    = exp_ivalid && irdy_in;

        @(posedge clk);
        if (rst_in) begin
            inflight.delete();
            decode_q.delete();
            model_pc    = RESET_PC;
            model_valid = 1'b1;
        end else if (model_valid) begin
            if (do_rsp) begin
                r = inflight.pop_front();
                if (r.live && !redir_in)
                    decode_q.push_back('{pc: r.pc, word: mem_word(r.pc)});
            end
            if (redir_in) begin
                foreach (inflight[i]) inflight[i].live = 1'b0;
                decode_q.delete();
                model_pc = {rpc_in[31:2], 2'b00};
            end else begin
                if (do_pop) void'(decode_q.pop_front());
                if (do_accept) begin
                    inflight.push_back('{pc: model_pc, live: 1'b1});
                    model_pc = model_pc + 32'd4;
                end
            end
        end
    endtask

    // Directed phases followed by random traffic.
    initial begin
        $display("[TB] starting instruction_fetch test");

        repeat (3) applyStimulus(1, 1, 1, 0, 0);

        // Streaming fetch from the reset address with an always-ready memory.
        rsp_prob = 100;
        accept_log.delete();
        pop_log.delete();
        repeat (20) applyStimulus(0, 1, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            checkLog("stream_addr", accept_log, i, RESET_PC + 32'(4 * i));
            checkLog("stream_pc", pop_log, i, RESET_PC + 32'(4 * i));
        end

        // Decode stalled: only two requests may be issued.
        repeat (2) applyStimulus(1, 1, 1, 0, 0);
        accept_log.delete();
        pop_log.delete();
        repeat (10) applyStimulus(0, 1, 0, 0, 0);
        checkOutput("stall_req_count", accept_log.size(), 2);
        checkLog("stall_addr0", accept_log, 0, RESET_PC);
        checkLog("stall_addr1", accept_log, 1, RESET_PC + 32'd4);
        repeat (6) applyStimulus(0, 1, 1, 0, 0);

        // Redirect with two requests outstanding; both stale words dropped.
        repeat (2) applyStimulus(1, 1, 1, 0, 0);
        repeat (4) applyStimulus(0, 1, 1, 0, 0);
        rsp_prob = 0;
        repeat (3) applyStimulus(0, 1, 1, 0, 0);
        rsp_prob = 100;
        accept_log.delete();
        pop_log.delete();
        applyStimulus(0, 1, 1, 1, 32'h0000_0103);
        repeat (8) applyStimulus(0, 1, 1, 0, 0);
        checkLog("redir_addr0", accept_log, 0, 32'h0000_0100);
        checkLog("redir_addr1", accept_log, 1, 32'h0000_0104);
        checkLog("redir_pc0", pop_log, 0, 32'h0000_0100);

        // Redirect near the top of the address space: fetch wraps to zero.
        accept_log.delete();
        pop_log.delete();
        applyStimulus(0, 1, 1, 1, 32'hFFFF_FFF8);
        repeat (10) applyStimulus(0, 1, 1, 0, 0);
        checkLog("wrap_addr0", accept_log, 0, 32'hFFFF_FFF8);
        checkLog("wrap_addr1", accept_log, 1, 32'hFFFF_FFFC);
        checkLog("wrap_addr2", accept_log, 2, 32'h0000_0000);
        checkLog("wrap_pc2", pop_log, 2, 32'h0000_0000);

        // Memory not ready for three cycles: address held, PC not advanced.
        repeat (3) applyStimulus(0, 1, 1, 0, 0);
        stall_addr = model_pc;
        accept_log.delete();
        repeat (3) applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 1, 1, 0, 0);
        checkOutput("held_req_count", accept_log.size(), 1);
        checkLog("held_addr", accept_log, 0, stall_addr);

        // Reset with a full buffer: contents abandoned, restart at RESET_PC.
        repeat (6) applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        accept_log.delete();
        pop_log.delete();
        repeat (12) applyStimulus(0, 1, 1, 0, 0);
        checkLog("post_rst_addr", accept_log, 0, RESET_PC);
        checkLog("post_rst_pc", pop_log, 0, RESET_PC);

        // Random traffic: backpressure on both sides, redirects, resets.
        rsp_prob = 60;
        repeat (400) begin
            applyStimulus($urandom_range(99) < 1, $urandom_range(99) < 75,
                          $urandom_range(99) < 70, $urandom_range(99) < 5,
                          $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the fetch address after reset.
REQ-002 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  meaning reset, synchronous and active-high.
REQ-004 SHALL have port imem_req_valid  output  1  meaning the fetch request is valid.
REQ-005 SHALL have port imem_req_ready  input  1  meaning the memory accepts the request.
REQ-006 SHALL have port imem_addr  output  32  meaning the fetch byte address, always word-aligned.
REQ-007 SHALL have port imem_rsp_valid  input  1  meaning the response word is valid; responses arrive in request order, at most one per cycle.
REQ-008 SHALL have port imem_rsp_data  input  32  meaning the fetched instruction word.
REQ-009 SHALL have port redirect_valid  input  1  meaning a branch/jump target is supplied this cycle.
REQ-010 SHALL have port redirect_pc  input  32  meaning the redirect target address.
REQ-011 SHALL have port instr_valid  output  1  meaning the instruction is valid for the decode stage.
REQ-012 SHALL have port instr_ready  input  1  meaning the decode stage accepts the instruction.
REQ-013 SHALL have port instruction  output  32  meaning the instruction word to decode.
REQ-014 SHALL have port instr_pc  output  32  meaning the address of the presented instruction.

Function
REQ-015 SHALL hold a fetch PC register; a request is accepted when imem_req_valid and imem_req_ready are both high, and imem_addr equals the fetch PC in that cycle.
REQ-016 SHALL advance the fetch PC by 4 on each accepted request, with modulo-2^32 wrap (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-017 SHALL track outstanding requests (0..2) and hold a 2-entry in-order buffer of {pc, word}.
REQ-018 SHALL assert imem_req_valid only when outstanding + buffer occupancy < 2, no discard is pending, and redirect_valid is low (credit flow control, so the buffer never overflows).
REQ-019 SHALL hold imem_req_valid and imem_addr stable while imem_req_valid is high and imem_req_ready is low, unless redirect_valid is high.
REQ-020 SHALL write a non-discarded response into the buffer tail tagged with its request PC; instr_valid rises the cycle after the write (1-cycle response-to-output latency).
REQ-021 SHALL drive instr_valid high whenever the buffer is non-empty, presenting the head entry on instruction and instr_pc.
REQ-022 SHALL pop the head when instr_valid and instr_ready are both high; a simultaneous pop and write in the same cycle SHALL keep occupancy unchanged.
REQ-023 SHALL keep instruction and instr_pc stable while instr_valid is high and instr_ready is low.
REQ-024 On redirect_valid, SHALL load fetch PC with {redirect_pc[31:2], 2'b00}, clear the buffer, and set the discard count to outstanding minus the response arriving that cycle (if any).
REQ-025 SHALL drop responses while the discard count is nonzero, decrementing the count per dropped response; a response arriving in the redirect cycle SHALL also be dropped.
REQ-026 Redirect SHALL take priority over a same-cycle pop and over a same-cycle response write.
REQ-027 SHALL resume requests at the redirected PC the first cycle in which the discard count is zero and REQ-018 allows it, at earliest the cycle after the redirect.
REQ-028 SHALL contain no combinational path from imem_rsp_* or instr_ready to instr_valid, or from instr_ready to imem_req_valid.

Reset
REQ-029 With rst high at a clock edge, SHALL set fetch PC = RESET_PC, outstanding = 0, discard = 0, and the buffer empty. This makes imem_req_valid = 0, instr_valid = 0, instruction = 0 and instr_pc = 0 in the cycle rst is high.
REQ-030 SHALL assert imem_req_valid with imem_addr = RESET_PC in the first cycle after rst deasserts; reset mid-operation SHALL abandon all in-flight responses and the buffer contents.

Verification
REQ-031 Setup: RESET_PC = 0, memory always ready with 1-cycle response, instr_ready = 1. Stimulus: release reset. Response: addresses 0, 4, 8, ... are requested; instr_pc follows the same sequence; each instruction matches memory.
REQ-032 Stimulus: hold instr_ready = 0 for 10 cycles. Response: exactly 2 requests are issued; the buffer holds PC 0 and PC 4; imem_req_valid = 0 until the first pop.
REQ-033 Stimulus: redirect_valid with redirect_pc = 32'h0000_0103 while 2 requests are outstanding. Response: both stale responses are dropped; the next request address is 32'h0000_0100; the next instr_pc is 32'h0000_0100.
REQ-034 Stimulus: redirect_pc = 32'hFFFF_FFF8. Response: fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000 in order.
REQ-035 Stimulus: imem_req_ready = 0 for 3 cycles. Response: imem_addr is held stable at the pending address, and the PC is not incremented until the request is accepted.
REQ-036 Stimulus: assert rst with the buffer full. Response: the next cycle shows instr_valid = 0; after release, the first request is at RESET_PC; no stale response reaches decode.
